// File: rtl/sample_mem_pkg.sv
// Shared definitions for the Avalon-MM sample memory: word width, the
// out-of-range read pattern and the byte-address to word-index mapping.
package sample_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] OOR_PATTERN = 32'hDEAD_BEEF;

  // Word index of a byte address relative to the window base; low two bits drop out.
  function automatic logic [63:0] word_index(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port synchronous sample RAM, one-cycle read latency.
// A write in the same cycle as a read of the same word returns the old contents.
module sample_ram
  import sample_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_sample_mem.sv
// Avalon-MM pipelined-read responder backed by sample RAM: accept logic, fixed-latency
// in-order return pipeline, pending-read throttling, optional stall injection and statistics.
module avalon_sample_mem
  import sample_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned MAX_PENDING  = 4,
  parameter int unsigned STALL_PERIOD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic              waitrequest,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [15:0]       oor_count,
  output logic              proto_err
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  logic [63:0]       idx;
  logic              in_range;
  logic              rd_acc;
  logic              wr_acc;
  logic              stall_tick;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] stage0_data;
  logic              rdv_raw;
  logic [WORD_W-1:0] rdata_raw;

  logic              vld0_d, vld0_q;
  logic              oor0_d, oor0_q;
  logic [PEND_W-1:0] pending_d, pending_q;
  logic [31:0]       rd_count_d, rd_count_q;
  logic [31:0]       wr_count_d, wr_count_q;
  logic [15:0]       oor_count_d, oor_count_q;
  logic              proto_err_d, proto_err_q;

  assign idx      = word_index(64'(address), 64'(BASE_ADDR));
  assign in_range = (64'(address) >= 64'(BASE_ADDR)) && ((idx >> DEPTH_LOG2) == 64'd0);

  // Depends only on registered state so the master can never form a combinational loop.
  assign waitrequest = ((pending_q == PEND_MAX) && !readdatavalid) || stall_tick;
  assign rd_acc      = read && !write && !waitrequest;
  assign wr_acc      = write && !read && !waitrequest;

  sample_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (clk),
    .en_i   (rd_acc || (wr_acc && in_range)),
    .we_i   (wr_acc && in_range),
    .addr_i (idx[DEPTH_LOG2-1:0]),
    .wdata_i(writedata),
    .rdata_o(ram_rdata)
  );

  assign stage0_data = oor0_q ? OOR_PATTERN : ram_rdata;

  if (READ_LATENCY > 1) begin : g_delay
    logic [READ_LATENCY-2:0] dly_vld_d, dly_vld_q;
    logic [WORD_W-1:0]       dly_data_d [READ_LATENCY-1];
    logic [WORD_W-1:0]       dly_data_q [READ_LATENCY-1];

    always_comb begin
      dly_vld_d[0]  = vld0_q;
      dly_data_d[0] = stage0_data;
      for (int i = 1; i < READ_LATENCY - 1; i++) begin
        dly_vld_d[i]  = dly_vld_q[i-1];
        dly_data_d[i] = dly_data_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        dly_vld_q <= '0;
      end else begin
        dly_vld_q <= dly_vld_d;
      end
      dly_data_q <= dly_data_d;
    end

    assign rdv_raw   = dly_vld_q[READ_LATENCY-2];
    assign rdata_raw = dly_data_q[READ_LATENCY-2];
  end else begin : g_no_delay
    assign rdv_raw   = vld0_q;
    assign rdata_raw = stage0_data;
  end

  assign readdatavalid = rdv_raw;
  // Data flops are not reset; masking keeps readdata at zero whenever no word is returned.
  assign readdata      = rdv_raw ? rdata_raw : '0;

  if (STALL_PERIOD > 0) begin : g_stall
    localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam logic [SW-1:0] LAST = SW'(STALL_PERIOD - 1);
    logic [SW-1:0] cnt_d, cnt_q;

    always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + SW'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stall_tick = (cnt_q == LAST);
  end else begin : g_no_stall
    assign stall_tick = 1'b0;
  end

  always_comb begin
    vld0_d      = rd_acc;
    oor0_d      = !in_range;
    pending_d   = pending_q + PEND_W'(rd_acc) - PEND_W'(readdatavalid);
    rd_count_d  = rd_count_q + 32'(rd_acc);
    wr_count_d  = wr_count_q + 32'(wr_acc);
    oor_count_d = oor_count_q;
    if ((rd_acc || wr_acc) && !in_range && (oor_count_q != 16'hFFFF)) begin
      oor_count_d = oor_count_q + 16'd1;
    end
    proto_err_d = proto_err_q || (read && write);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld0_q      <= 1'b0;
      oor0_q      <= 1'b0;
      pending_q   <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      oor_count_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      vld0_q      <= vld0_d;
      oor0_q      <= oor0_d;
      pending_q   <= pending_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      oor_count_q <= oor_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign oor_count = oor_count_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_avalon_sample_mem.sv
// Scoreboard bench for avalon_sample_mem: three instances (default, long latency with
// throttling, periodic stall) driven by directed transactions; a monitor checks returns.
module tb_avalon_sample_mem;

  localparam int NDUT = 3;

  typedef struct {
    int          k;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] address       [NDUT];
  logic        read          [NDUT];
  logic        write         [NDUT];
  logic [31:0] writedata     [NDUT];
  logic        waitrequest   [NDUT];
  logic [31:0] readdata      [NDUT];
  logic        readdatavalid [NDUT];
  logic [31:0] rd_count      [NDUT];
  logic [31:0] wr_count      [NDUT];
  logic [15:0] oor_count     [NDUT];
  logic        proto_err     [NDUT];

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  int   nrd [NDUT];
  int   nwr [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned LAT = (g == 1) ? 6 : 3;
    localparam int unsigned SP  = (g == 2) ? 3 : 0;
    avalon_sample_mem #(
      .READ_LATENCY(LAT),
      .MAX_PENDING (4),
      .STALL_PERIOD(SP)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address[g]),
      .read         (read[g]),
      .write        (write[g]),
      .writedata    (writedata[g]),
      .waitrequest  (waitrequest[g]),
      .readdata     (readdata[g]),
      .readdatavalid(readdatavalid[g]),
      .rd_count     (rd_count[g]),
      .wr_count     (wr_count[g]),
      .oor_count    (oor_count[g]),
      .proto_err    (proto_err[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return (k == 1) ? 6 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h required %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int k);
    checks++;
    failures++;
    $display("FAIL %s dut%0d: got no accept, required accept within 50 cycles", name, k);
  endtask

  // Called at a negedge; holds the request until waitrequest is seen low.
  task automatic wr(input int k, input logic [23:0] a, input logic [31:0] d, output int acc);
    int n = 0;
    address[k] = a;
    writedata[k] = d;
    write[k] = 1'b1;
    while (waitrequest[k] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("wr_timeout", k);
    acc = cyc;
    @(negedge clk);
    write[k] = 1'b0;
    nwr[k]++;
  endtask

  task automatic rd(input int k, input logic [23:0] a, input logic [31:0] d, input bit push,
                    output int acc);
    int n = 0;
    address[k] = a;
    read[k] = 1'b1;
    while (waitrequest[k] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("rd_timeout", k);
    acc = cyc;
    if (push) sb.push_back('{k: k, data: d, cyc: cyc + lat(k)});
    @(negedge clk);
    read[k] = 1'b0;
    nrd[k]++;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_idle(input int k);
    check($sformatf("rst_rdv%0d", k), 32'(readdatavalid[k]), 32'd0);
    check($sformatf("rst_rdata%0d", k), readdata[k], 32'd0);
    check($sformatf("rst_rdcnt%0d", k), rd_count[k], 32'd0);
    check($sformatf("rst_wrcnt%0d", k), wr_count[k], 32'd0);
    check($sformatf("rst_oor%0d", k), 32'(oor_count[k]), 32'd0);
    check($sformatf("rst_proto%0d", k), 32'(proto_err[k]), 32'd0);
    check($sformatf("rst_wait%0d", k), 32'(waitrequest[k]), 32'd0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (readdatavalid[k] === 1'b1) begin
        int hit;
        hit = -1;
        for (int j = 0; j < sb.size(); j++) if (hit < 0 && sb[j].k == k) hit = j;
        if (hit < 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rdv dut%0d: got data %08h, required no return", k, readdata[k]);
        end else begin
          check($sformatf("ret_data dut%0d", k), readdata[k], sb[hit].data);
          check($sformatf("ret_cycle dut%0d", k), 32'(cyc), 32'(sb[hit].cyc));
          sb.delete(hit);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int a;
    int acc8 [8];
    int offs [8] = '{0, 1, 2, 3, 6, 7, 8, 9};

    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      address[k] = '0;
      read[k] = 1'b0;
      write[k] = 1'b0;
      writedata[k] = '0;
      nrd[k] = 0;
      nwr[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel_cyc = cyc;
    for (int k = 0; k < NDUT; k++) check_idle(k);

    // Basic writes then back-to-back reads
    for (int i = 0; i < 4; i++) wr(0, 24'(i * 4), 32'h1111_1101 + 32'(i), a);
    for (int i = 0; i < 4; i++) rd(0, 24'(i * 4), 32'h1111_1101 + 32'(i), 1'b1, a);
    drain();
    check("rd_count_basic", rd_count[0], 32'd4);
    check("wr_count_basic", wr_count[0], 32'd4);

    // Read-after-write next cycle, then write while that word is in flight
    wr(0, 24'h1C, 32'hA5A5_A5A5, a);
    rd(0, 24'h1C, 32'hA5A5_A5A5, 1'b1, a);
    wr(0, 24'h1C, 32'h5A5A_5A5A, a);
    rd(0, 24'h1C, 32'h5A5A_5A5A, 1'b1, a);
    drain();

    // Out of range: first word past the RAM aliases word 0 if the index were truncated
    rd(0, 24'h1000, 32'hDEAD_BEEF, 1'b1, a);
    wr(0, 24'h1000, 32'h1234_5678, a);
    rd(0, 24'h0, 32'h1111_1101, 1'b1, a);
    drain();
    check("oor_count", 32'(oor_count[0]), 32'd2);
    check("rd_count_total", rd_count[0], 32'(nrd[0]));
    check("wr_count_total", wr_count[0], 32'(nwr[0]));

    // Throttling on the long-latency instance
    for (int i = 0; i < 8; i++) wr(1, 24'(i * 4), 32'h0000_0100 + 32'(i), a);
    for (int i = 0; i < 8; i++) rd(1, 24'(i * 4), 32'h0000_0100 + 32'(i), 1'b1, acc8[i]);
    for (int i = 1; i < 8; i++) check($sformatf("throttle_acc%0d", i), 32'(acc8[i] - acc8[0]),
                                      32'(offs[i]));
    drain();

    // Stall injection: waitrequest every third cycle counted from reset release
    for (int i = 0; i < 6; i++) begin
      check("stall_wait", 32'(waitrequest[2]), 32'(((cyc - rel_cyc) % 3) == 2));
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      wr(2, 24'(i * 4), 32'h0000_0200 + 32'(i), a);
      check("stall_acc_not_on_tick", 32'(((a - rel_cyc) % 3) == 2), 32'd0);
    end
    for (int i = 0; i < 6; i++) rd(2, 24'(i * 4), 32'h0000_0200 + 32'(i), 1'b1, a);
    drain();
    check("stall_wr_count", wr_count[2], 32'd6);
    check("stall_rd_count", rd_count[2], 32'd6);

    // Protocol error: simultaneous read and write accepts nothing
    address[0] = 24'h4;
    writedata[0] = 32'hFFFF_0000;
    read[0] = 1'b1;
    write[0] = 1'b1;
    @(negedge clk);
    read[0] = 1'b0;
    write[0] = 1'b0;
    check("proto_err_set", 32'(proto_err[0]), 32'd1);
    repeat (5) @(negedge clk);
    check("proto_rd_count", rd_count[0], 32'(nrd[0]));
    check("proto_wr_count", wr_count[0], 32'(nwr[0]));

    // Reset with two reads in flight: none of them may return
    rd(0, 24'h0, 32'h0, 1'b0, a);
    rd(0, 24'h4, 32'h0, 1'b0, a);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    reset = 1'b0;
    rel_cyc = cyc;
    for (int k = 0; k < NDUT; k++) begin
      nrd[k] = 0;
      nwr[k] = 0;
    end
    check_idle(0);
    check_idle(2);
    repeat (10) @(negedge clk);

    // Writes made before reset persist
    rd(0, 24'h1C, 32'h5A5A_5A5A, 1'b1, a);
    rd(0, 24'h4, 32'h1111_1102, 1'b1, a);
    drain();
    check("post_reset_rd_count", rd_count[0], 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
